// File: rtl/morph_pkg.sv
// Shared definitions for the streaming morphology engine: op codes, FSM states,
// parameter defaults and the input-to-output latency.
package morph_pkg;

    typedef enum logic [2:0] {
        OP_BYPASS = 3'b000,
        OP_ERODE  = 3'b010,
        OP_DILATE = 3'b011,
        OP_GRAD   = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } state_e;

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_PPW   = 4;
    localparam int DEF_SE_K  = 4;

    // Cycles from sampling word 0 to presenting output word 0.
    function automatic int morph_latency(input int img_w, input int ppw, input int se_k);
        int wpr;
        wpr = img_w / ppw;
        return (se_k - 1) * wpr + (se_k - 1 + ppw - 1) / ppw + 1;
    endfunction

endpackage

// File: rtl/morph_window_kernel.sv
// One output pixel from an SE_K x SE_K window: saturating erosion and dilation
// reductions, gradient as their difference, or a pass-through of the anchor pixel.
module morph_window_kernel
    import morph_pkg::*;
#(
    parameter int SE_K = DEF_SE_K
) (
    input  logic [SE_K*SE_K*8-1:0] win,
    input  logic [SE_K*SE_K*8-1:0] se,
    input  logic [2:0]             op,
    output logic [7:0]             pix
);

    localparam int SE_N = SE_K * SE_K;

    logic [7:0] ero;
    logic [7:0] dil;
    logic [7:0] diff;
    logic [7:0] addv;
    logic [8:0] sum;

    // NOTE: every variable gets a default before the loop, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        ero  = 8'hFF;
        dil  = 8'h00;
        diff = 8'h00;
        addv = 8'h00;
        sum  = 9'h000;
        // NOTE: blocking assignments here, so each iteration sees the running min/max.
        for (int i = 0; i < SE_N; i++) begin
            diff = (win[i*8 +: 8] > se[i*8 +: 8]) ? win[i*8 +: 8] - se[i*8 +: 8] : 8'h00;
            sum  = {1'b0, win[i*8 +: 8]} + {1'b0, se[(SE_N-1-i)*8 +: 8]};
            addv = sum[8] ? 8'hFF : sum[7:0];
            if (diff < ero) ero = diff;
            if (addv > dil) dil = addv;
        end
    end

    // Dilation never falls below erosion, so the gradient cannot underflow.
    always_comb begin
        case (op)
            OP_ERODE:  pix = ero;
            OP_DILATE: pix = dil;
            OP_GRAD:   pix = dil - ero;
            default:   pix = win[7:0];
        endcase
    end

endmodule

// File: rtl/morph_stream_engine.sv
// Streaming grayscale morphology: a word-wide delay line spanning SE_K-1 rows plus
// the right-hand overhang feeds PPW window kernels; zeros are injected to drain.
module morph_stream_engine
    import morph_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PPW   = DEF_PPW,
    parameter int SE_K  = DEF_SE_K
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [PPW*8-1:0] pic_data,
    input  logic [7:0]       se_data,
    output logic             out_valid,
    output logic [PPW*8-1:0] out_data
);

    localparam int WPR     = IMG_W / PPW;
    localparam int N_WORDS = IMG_H * WPR;
    localparam int D       = morph_latency(IMG_W, PPW, SE_K);
    localparam int SE_N    = SE_K * SE_K;
    localparam int EXT     = (SE_K - 1 + PPW - 1) / PPW;
    localparam int DLY     = D - 1;
    localparam int CNT_W   = $clog2(N_WORDS + D);
    localparam int COL_W   = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int SE_IW   = (SE_N > 1) ? $clog2(SE_N) : 1;

    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(N_WORDS + D - 2);
    localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] SE_END    = CNT_W'(SE_N);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WPR - 1);

    if (IMG_W % PPW != 0) begin : g_bad_width
        $error("IMG_W must be a multiple of PPW");
    end
    if (SE_N >= D) begin : g_bad_se
        $error("SE load must finish before the first output word");
    end

    state_e           state;
    logic [CNT_W-1:0] pos_cnt;
    logic [COL_W-1:0] out_col;
    logic [2:0]       op_reg;
    logic [7:0]       se_mem [SE_N];
    logic [SE_N*8-1:0] se_flat;

    logic [PPW*8-1:0] dly  [DLY];
    logic [PPW*8-1:0] taps [D];
    logic [PPW*8-1:0] in_word;
    logic [PPW*8-1:0] res_word;
    logic [PPW*SE_N*8-1:0] win_flat;
    logic [EXT:0]     col_ok;
    logic             shift_en;
    logic             accept;
    logic             emit;

    assign accept   = in_valid && (state != S_DRAIN);
    assign shift_en = accept || (state == S_DRAIN);
    assign in_word  = accept ? pic_data : '0;
    assign emit     = shift_en && (pos_cnt >= FIRST_OUT);

    // NOTE: the delay line is reset like any other state so a new frame never sees
    // pixels left over from an abandoned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) dly[i] <= '0;
        end else if (shift_en) begin
            dly[0] <= in_word;
            for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
        end
    end

    // taps[j] is the word j positions older than the one arriving this cycle.
    always_comb begin
        taps[0] = in_word;
        for (int j = 1; j < D; j++) taps[j] = dly[j-1];
    end

    for (genvar g = 0; g < SE_N; g++) begin : g_se
        assign se_flat[g*8 +: 8] = se_mem[g];
    end

    for (genvar j = 0; j <= EXT; j++) begin : g_col_ok
        assign col_ok[j] = (int'(out_col) + j) < WPR;
    end

    // Neighbour words past the row end belong to the next row and read as zero.
    for (genvar p = 0; p < PPW; p++) begin : g_pix
        for (genvar k = 0; k < SE_K; k++) begin : g_row
            for (genvar kk = 0; kk < SE_K; kk++) begin : g_col
                localparam int WOFF = (p + kk) / PPW;
                localparam int PSEL = (p + kk) % PPW;
                localparam int TAP  = D - 1 - k * WPR - WOFF;
                localparam int WBIT = (p * SE_N + k * SE_K + kk) * 8;
                assign win_flat[WBIT +: 8] = col_ok[WOFF] ? taps[TAP][PSEL*8 +: 8] : 8'h00;
            end
        end

        morph_window_kernel #(.SE_K(SE_K)) u_kernel (
            .win (win_flat[p*SE_N*8 +: SE_N*8]),
            .se  (se_flat),
            .op  (op_reg),
            .pix (res_word[p*8 +: 8])
        );
    end

    // NOTE: non-blocking assignments for all registered state, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pos_cnt   <= '0;
            out_col   <= '0;
            op_reg    <= OP_BYPASS;
            for (int i = 0; i < SE_N; i++) se_mem[i] <= 8'h00;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (shift_en)
                pos_cnt <= (state == S_DRAIN && pos_cnt == LAST_POS) ? '0 : pos_cnt + 1'b1;

            case (state)
                S_IDLE:  if (in_valid) state <= S_FILL;
                S_FILL:  if (in_valid && pos_cnt == LAST_IN) state <= S_DRAIN;
                S_DRAIN: if (pos_cnt == LAST_POS) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (accept && op_valid && pos_cnt < FIRST_OUT) op_reg <= op;
            if (accept && pos_cnt < SE_END) se_mem[pos_cnt[SE_IW-1:0]] <= se_data;

            if (emit) out_col <= (out_col == LAST_COL) ? '0 : out_col + 1'b1;
            out_valid <= emit;
            out_data  <= emit ? res_word : '0;
        end
    end

endmodule
